// File: rtl/seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seq_scan_ctrl
//   Sequencing controller for a serial sequence detector. A W-bit word is
//   accepted on a valid/ready input and shifted MSB-first into the detector's
//   serial input, one bit per clock. The detector's match pulses that complete
//   on bits of the word are counted. The count is then returned on a
//   valid/ready output. The block also owns the detector's pattern register,
//   which can only be reloaded while IDLE.
//
// Ports
//   clk        in   1            clock, rising edge
//   reset_n    in   1            asynchronous active-low reset
//   pat_load   in   1            capture pat_in into det_seq (IDLE only)
//   pat_in     in   N            new detection pattern
//   in_valid   in   1            in_data is valid
//   in_ready   out  1            word can be accepted (IDLE only)
//   in_data    in   W            word to scan, bit W-1 goes out first
//   det_a      out  1            serial bit to the detector
//   det_seq    out  N            pattern to the detector
//   det_valid  in   1            detector match pulse (registered in detector)
//   out_valid  out  1            out_count is valid
//   out_ready  in   1            consumer accepts out_count
//   out_count  out  clog2(W+1)   matches completing within the word
//   busy       out  1            high whenever not IDLE
// -----------------------------------------------------------------------------
module seq_scan_ctrl #(
   parameter int N = 6,
   parameter int W = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   pat_load,
   input  logic [N-1:0]           pat_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_data,
   output logic                   det_a,
   output logic [N-1:0]           det_seq,
   input  logic                   det_valid,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(W+1)-1:0] out_count,
   output logic                   busy
);

   localparam int CW = $clog2(W + 1);
   localparam int KW = $clog2(W + 1);

   // A det_valid seen in cycle k reports the bit driven in cycle k-1, so the
   // first match that lies entirely inside the word shows up at k = N.
   localparam logic [KW-1:0] K_FIRST_COUNTED = KW'(N);
   localparam logic [KW-1:0] K_LAST          = KW'(W - 1);

   generate
      if (W < N) begin : g_width_check
         $error("seq_scan_ctrl: W must be >= N");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state;
   logic [W-1:0]    shift_reg;
   logic [KW-1:0]   k;
   logic [CW-1:0]   match_cnt;

   // Controller FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         k         <= '0;
         match_cnt <= '0;
         det_a     <= 1'b0;
         det_seq   <= '0;
         out_valid <= 1'b0;
         out_count <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               det_a <= 1'b0;
               // A pattern loaded on the acceptance edge is the one the word
               // is scanned against, since det_seq updates on that same edge.
               if (pat_load) begin
                  det_seq <= pat_in;
               end else begin
                  det_seq <= det_seq;
               end
               if (in_valid) begin
                  // Bit W-1 goes out during k=0, so it is put on det_a here and
                  // the remaining bits are pre-shifted up.
                  det_a     <= in_data[W-1];
                  shift_reg <= in_data << 1'b1;
                  k         <= '0;
                  match_cnt <= '0;
                  state     <= ST_SHIFT;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_SHIFT: begin
               // Earlier pulses belong to matches ending on pre-word bits.
               if (det_valid && (k >= K_FIRST_COUNTED)) begin
                  match_cnt <= match_cnt + CW'(1);
               end else begin
                  match_cnt <= match_cnt;
               end
               if (k == K_LAST) begin
                  det_a <= 1'b0;
                  state <= ST_DRAIN;
               end else begin
                  det_a     <= shift_reg[W-1];
                  shift_reg <= shift_reg << 1'b1;
                  k         <= k + KW'(1);
               end
            end

            ST_DRAIN: begin
               // The pulse for the last word bit arrives in this cycle.
               det_a     <= 1'b0;
               out_count <= match_cnt + CW'(det_valid);
               out_valid <= 1'b1;
               state     <= ST_DONE;
            end

            ST_DONE: begin
               det_a <= 1'b0;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_DONE;
               end
            end

            default: begin
               det_a     <= 1'b0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_scan_ctrl
//   Self-checking bench for seq_scan_ctrl with N=4, W=8. A behavioural
//   non-overlapping serial detector stands in for the real one. Expected
//   counts come from a hand-computed vector table and from a word-level
//   reference function that replays the word bits through the detector rules.
// -----------------------------------------------------------------------------
module tb_seq_scan_ctrl;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk;
   logic          reset_n;
   logic          pat_load;
   logic [N-1:0]  pat_in;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          det_a;
   logic [N-1:0]  det_seq;
   logic          det_valid;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_count;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] cur_pat;
   int           exp_cnt;

   seq_scan_ctrl #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .det_a     (det_a),
      .det_seq   (det_seq),
      .det_valid (det_valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural detector: N-bit history, fill count reset after a match.
   logic [N-1:0] m_hist;
   int           m_fill;
   logic [N-1:0] m_next;
   assign m_next = {m_hist[N-2:0], det_a};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hist    <= '0;
         m_fill    <= 0;
         det_valid <= 1'b0;
      end else begin
         m_hist <= m_next;
         if ((m_fill + 1 >= N) && (m_next == det_seq)) begin
            det_valid <= 1'b1;
            m_fill    <= 0;
         end else begin
            det_valid <= 1'b0;
            m_fill    <= (m_fill + 1 >= N) ? N : m_fill + 1;
         end
      end
   end

   // Word-level reference: feed the word bits MSB first from the detector
   // state at acceptance, counting matches that end on word bit N-1 or later.
   function automatic int ref_count(input logic [W-1:0] word, input logic [N-1:0] h0,
                                    input int f0, input logic [N-1:0] pat);
      logic [N-1:0] h;
      int f;
      int c;
      h = h0;
      f = f0;
      c = 0;
      for (int j = 0; j < W; j++) begin
         h = {h[N-2:0], word[W-1-j]};
         f = f + 1;
         if (f >= N && h == pat) begin
            if (j >= N - 1) c = c + 1;
            f = 0;
         end
      end
      return c;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present a word (optionally with a pattern load) and take the acceptance edge.
   task automatic accept(input logic ld, input logic [N-1:0] pat, input logic [W-1:0] word);
      int w;
      w = 0;
      while (!in_ready && w < 30) begin
         tick();
         w++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      in_valid = 1'b1;
      in_data  = word;
      pat_load = ld;
      pat_in   = pat;
      tick();
      in_valid = 1'b0;
      pat_load = 1'b0;
      if (ld) cur_pat = pat;
      exp_cnt = ref_count(word, m_hist, m_fill, cur_pat);
      chk("busy_after_accept", busy, 1);
   endtask

   // Wait for out_valid, check latency and count, stall `hold` cycles, handshake.
   task automatic finish(input int already, input int hold, input int exp);
      int lat;
      lat = already;
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
      chk("latency", lat, W + 1);
      chk("out_count", out_count, exp);
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_out_count", out_count, exp);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_dropped", out_valid, 0);
      chk("idle_after_done", busy, 0);
   endtask

   typedef struct {
      logic [N-1:0] pat;
      logic [W-1:0] word;
      int           exp;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] old_pat;
      logic [N-1:0] rpat;
      logic [W-1:0] rword;
      logic         rld;

      // Expected counts worked out by hand with an all-zero detector history.
      tbl[0]  = '{4'b1011, 8'hBB, 2};
      tbl[1]  = '{4'b1111, 8'hFF, 2};
      tbl[2]  = '{4'b1111, 8'h00, 0};
      tbl[3]  = '{4'b0110, 8'h66, 2};
      tbl[4]  = '{4'b1010, 8'hAA, 2};
      tbl[5]  = '{4'b0001, 8'h11, 2};
      tbl[6]  = '{4'b0001, 8'h80, 0};   // match ends on word bit 0: not counted
      tbl[7]  = '{4'b0011, 8'hC0, 0};   // match ends on word bit 1: not counted
      tbl[8]  = '{4'b0001, 8'h08, 1};   // first match counted, bit N-1+1
      tbl[9]  = '{4'b0101, 8'h55, 2};   // non-overlapping, not 3
      tbl[10] = '{4'b1111, 8'hFE, 1};

      reset_n   = 1'b0;
      pat_load  = 1'b0;
      pat_in    = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      cur_pat   = '0;
      exp_cnt   = 0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_det_seq", det_seq, 0);
      chk("rst_det_a", det_a, 0);
      tick();
      reset_n = 1'b1;
      idle(2);

      // Table vectors, each loading its pattern with the word.
      for (int i = 0; i < 11; i++) begin
         idle(N + 1);
         accept(1'b1, tbl[i].pat, tbl[i].word);
         finish(0, 0, tbl[i].exp);
      end

      // Back-to-back FF then 00 with pattern 1111.
      accept(1'b1, 4'b1111, 8'hFF);
      finish(0, 0, 2);
      accept(1'b0, 4'b0000, 8'h00);
      finish(0, 0, 0);

      // Stall in DONE: outputs stable, input side closed, in_valid ignored.
      idle(N + 1);
      accept(1'b1, 4'b1011, 8'hBB);
      begin
         int lat;
         lat = 0;
         while (!out_valid && lat < 30) begin
            tick();
            lat++;
         end
         chk("stall_latency", lat, W + 1);
         for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 8'h3C;
            tick();
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_count", out_count, 2);
            chk("stall_in_ready", in_ready, 0);
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("stall_release", out_valid, 0);
         tick();
         chk("stall_no_accept", busy, 0);
      end

      // pat_load during SHIFT is ignored; in IDLE it takes effect next edge.
      idle(N + 1);
      accept(1'b1, 4'b1011, 8'hBB);
      old_pat = det_seq;
      tick();
      pat_load = 1'b1;
      pat_in   = 4'b0110;
      tick();
      pat_load = 1'b0;
      chk("shift_pat_ignored", det_seq, 4'b1011);
      finish(2, 0, 2);
      chk("pat_before_idle_load", det_seq, old_pat);
      pat_load = 1'b1;
      pat_in   = 4'b0110;
      tick();
      pat_load = 1'b0;
      cur_pat  = 4'b0110;
      chk("idle_pat_load", det_seq, 4'b0110);

      // Reset at k=4 of SHIFT.
      idle(N + 1);
      accept(1'b1, 4'b1011, 8'hBB);
      idle(4);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_det_seq", det_seq, 0);
      chk("midrst_in_ready", in_ready, 1);
      tick();
      reset_n = 1'b1;
      cur_pat = '0;
      idle(2);
      accept(1'b1, 4'b1011, 8'hBB);
      chk("midrst_ref_agrees", exp_cnt, 2);
      finish(0, 1, 2);

      // Randomised words against the reference function.
      for (int i = 0; i < 40; i++) begin
         rld   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rpat  = N'($urandom_range(0, 15));
         rword = W'($urandom);
         idle($urandom_range(0, 2));
         accept(rld, rpat, rword);
         chk("rand_det_seq", det_seq, cur_pat);
         finish(0, $urandom_range(0, 2), exp_cnt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
